// File: rtl/cache_nway_pkg.sv
// Shared types and tree-PLRU helpers for the N-way write-back cache controller.
package cache_nway_pkg;

  typedef enum logic {cpu = 1'b0, memory = 1'b1} dimux_sel_t;

  typedef enum logic [1:0] {zeros = 2'd0, cpu_mbe = 2'd1, ones = 2'd2} wemux_sel_t;

  typedef enum logic {from_cpu = 1'b0, from_victim_tag = 1'b1} addrmux_sel_t;

  typedef enum logic [1:0] {HIT_CHECK, WRITE_BACK, READ_BACK} state_e;

  // First node index of a tree level (heap layout, root at 0).
  function automatic int plru_level_base(input int depth);
    return (1 << depth) - 1;
  endfunction

  // Index of the node at a given depth and left-to-right position.
  function automatic int plru_node(input int depth, input int pos);
    return plru_level_base(depth) + pos;
  endfunction

endpackage

// File: rtl/cache_control_nway_plru_tree.sv
// Combinational tree-PLRU: update on access and victim walk.
module plru_tree
  import cache_nway_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] plru_i,
  input  logic [WAY_W-1:0]    access_way,
  output logic [NUM_WAYS-2:0] plru_o,
  output logic [WAY_W-1:0]    victim
);

  // At depth d the path node is selected by the top d bits of the way index;
  // the way bit at that depth says which child the path takes.
  always_comb begin
    plru_o = plru_i;
    victim = '0;
    for (int d = 0; d < WAY_W; d++) begin
      for (int p = 0; p < (1 << d); p++) begin
        if ((access_way >> (WAY_W - d)) == WAY_W'(p))
          plru_o[plru_node(d, p)] = ~access_way[WAY_W-1-d];
        if ((victim >> (WAY_W - d)) == WAY_W'(p))
          victim[WAY_W-1-d] = plru_i[plru_node(d, p)];
      end
    end
  end

endmodule

// File: rtl/cache_control_nway.sv
// N-way write-back cache controller FSM with tree-PLRU replacement.
// Optional perf counters (hit/miss/write-back) under CACHE_NWAY_PERF_CNT_EN.
module cache_control_nway
  import cache_nway_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int CNT_W    = 32,
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WAYS-1:0]          valid_i,
  input  logic [NUM_WAYS-1:0]          dirty_i,
  input  logic [NUM_WAYS-1:0]          cmp_i,
  input  logic [NUM_WAYS-2:0]          plru_i,
  output dimux_sel_t                   dimux_sel,
  output logic [WAY_W-1:0]             domux_sel,
  output wemux_sel_t [NUM_WAYS-1:0]    wemux_sel,
  output addrmux_sel_t                 addrmux_sel,
  output logic [WAY_W-1:0]             victim_way_o,
  output logic                         plru_load,
  output logic [NUM_WAYS-2:0]          plru_o,
  output logic [NUM_WAYS-1:0]          valid_load,
  output logic [NUM_WAYS-1:0]          valid_o,
  output logic [NUM_WAYS-1:0]          dirty_load,
  output logic [NUM_WAYS-1:0]          dirty_o,
  output logic [NUM_WAYS-1:0]          tag_load,
  input  logic                         mem_read,
  input  logic                         mem_write,
  output logic                         mem_resp,
  input  logic                         pmem_resp,
  output logic                         pmem_read,
  output logic                         pmem_write
`ifdef CACHE_NWAY_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             miss_cnt,
  output logic [CNT_W-1:0]             wb_cnt
`endif
);

  if (NUM_WAYS < 2 || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
    $error("NUM_WAYS must be a power of two >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be >= 1");
  end

  state_e               state, state_n;
  logic [WAY_W-1:0]     victim_q;
  logic [NUM_WAYS-1:0]  hit_vec;
  logic                 req, hit, inval_any;
  logic [WAY_W-1:0]     hit_way, inval_way, plru_victim, miss_victim;
  logic [NUM_WAYS-2:0]  plru_upd;

  assign req     = mem_read | mem_write;
  assign hit_vec = valid_i & cmp_i;
  assign hit     = |hit_vec;

  // Lowest index wins for both hit and invalid-way search.
  always_comb begin
    hit_way   = '0;
    inval_way = '0;
    inval_any = 1'b0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WAY_W'(i);
      if (!valid_i[i]) begin
        inval_way = WAY_W'(i);
        inval_any = 1'b1;
      end
    end
  end

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .plru_i     (plru_i),
    .access_way (hit_way),
    .plru_o     (plru_upd),
    .victim     (plru_victim)
  );

  assign miss_victim  = inval_any ? inval_way : plru_victim;
  assign victim_way_o = victim_q;
  assign plru_o       = plru_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HIT_CHECK;
      victim_q <= '0;
    end else begin
      state <= state_n;
      if (state == HIT_CHECK && req && !hit) victim_q <= miss_victim;
    end
  end

  always_comb begin
    state_n     = state;
    mem_resp    = 1'b0;
    plru_load   = 1'b0;
    dimux_sel   = cpu;
    domux_sel   = '0;
    addrmux_sel = from_cpu;
    valid_load  = '0;
    valid_o     = '0;
    dirty_load  = '0;
    dirty_o     = '0;
    tag_load    = '0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) wemux_sel[i] = zeros;
    case (state)
      HIT_CHECK: begin
        if (req && hit) begin
          mem_resp  = 1'b1;
          plru_load = 1'b1;
          if (mem_write) begin
            wemux_sel[hit_way]  = cpu_mbe;
            dirty_load[hit_way] = 1'b1;
            dirty_o[hit_way]    = 1'b1;
          end else begin
            domux_sel = hit_way;
          end
        end else if (req) begin
          state_n = (valid_i[miss_victim] && dirty_i[miss_victim]) ? WRITE_BACK : READ_BACK;
        end
      end
      WRITE_BACK: begin
        pmem_write  = 1'b1;
        addrmux_sel = from_victim_tag;
        domux_sel   = victim_q;
        if (pmem_resp) state_n = READ_BACK;
      end
      READ_BACK: begin
        pmem_read          = 1'b1;
        dimux_sel          = memory;
        valid_o[victim_q]  = 1'b1;
        // Line metadata commits only with the completed fill, so an aborted
        // fill never leaves a half-written line marked valid.
        if (pmem_resp) begin
          wemux_sel[victim_q]  = ones;
          tag_load[victim_q]   = 1'b1;
          valid_load[victim_q] = 1'b1;
          dirty_load[victim_q] = 1'b1;
          state_n              = HIT_CHECK;
        end
      end
      default: state_n = HIT_CHECK;
    endcase
  end

`ifdef CACHE_NWAY_PERF_CNT_EN
  logic hit_evt, miss_evt, wb_evt;
  assign hit_evt  = (state == HIT_CHECK) && req && hit;
  assign miss_evt = (state == HIT_CHECK) && req && !hit;
  assign wb_evt   = miss_evt && (state_n == WRITE_BACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_evt  && !(&hit_cnt))  hit_cnt  <= hit_cnt  + 1'b1;
      if (miss_evt && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
      if (wb_evt   && !(&wb_cnt))   wb_cnt   <= wb_cnt   + 1'b1;
    end
  end
`endif

endmodule
